cu_read_response_engine: RTL and testbench
==========================================

Name: cu_read_response_engine

Overview:
- Services CU read commands (CommandBufferLine) on the PSL side and closes the loop back to the CU.
- Allocates a PSL tag per command, stores the command's cmd payload, and issues the command to the PSL.
- Reassembles returned buffer-write data into read_data_0/read_data_1 half-lines and returns the matching ResponseBufferLine.
- Sits between the CU command arbiter and the PSL command/buffer/response interfaces. It produces exactly the read_response/read_data stream that CU job controllers consume.

Parameters:
NUM_TAGS, 32, outstanding read commands tracked (power of 2, max 256)
TAG_WIDTH, 8, PSL tag width

Ports:
clock  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
enabled  in  1  global enable; when low, no accept/issue, outputs hold
command_in  in  $bits(CommandBufferLine)  read command from CU (valid, command, address, size, cmd)
command_ready  out  1  at least one free tag
ah_cvalid  out  1  PSL command valid
ah_ctag  out  TAG_WIDTH  PSL command tag
ah_com  out  13  PSL command code (command_in.command)
ah_cea  out  64  effective address
ah_csize  out  12  transfer size in bytes
ha_bwvalid  in  1  buffer write valid
ha_bwtag  in  TAG_WIDTH  buffer write tag
ha_bwad  in  6  buffer write address; bit 0 selects half
ha_bwdata  in  512  half-cacheline data
ha_rvalid  in  1  response valid
ha_rtag  in  TAG_WIDTH  response tag
ha_response  in  8  response code (0x00 = DONE)
read_data_0_out  out  $bits(ReadWriteDataLine)  first 64B half plus cmd
read_data_1_out  out  $bits(ReadWriteDataLine)  second 64B half plus cmd
read_response_out  out  $bits(ResponseBufferLine)  completion plus cmd and response code
outstanding  out  9  busy tag count
protocol_error  out  1  sticky: bwvalid/rvalid for a non-busy tag, or command with ready low

Behaviour:
Reset (async, rst=1):
- All outputs 0, all tags free, outstanding=0, protocol_error=0.
- Reset mid-operation discards in-flight commands; no responses are generated for them.

Accept:
- Accept when command_in.valid && command_ready && enabled.
- Allocate the lowest-index free tag; store cmd, address, size in the tag table; mark the tag busy.
- command_in.valid while command_ready=0: command dropped, protocol_error set.

Issue:
- ah_cvalid pulses one cycle, registered one cycle after accept (1-cycle latency).
- ah_ctag = allocated tag; ah_com/ah_cea/ah_csize copied from command_in.
- Back-to-back accepts give back-to-back issues.

Buffer write:
- On ha_bwvalid for a busy tag: one cycle later, read_data_{ha_bwad[0]}_out.valid=1 with data=ha_bwdata and cmd = stored cmd of that tag.
- Only one of the two data outputs is valid per cycle; each is a single-cycle pulse.
- Buffer write to a non-busy tag: dropped, protocol_error set.

Response:
- On ha_rvalid for a busy tag: one cycle later, read_response_out.valid=1 with response=ha_response and cmd = stored cmd; the tag is freed in the same cycle.
- Non-DONE codes are forwarded unchanged and still free the tag; there is no retry.
- Response to a non-busy tag: dropped, protocol_error set.

Simultaneous events:
- Accept and response on different tags in the same cycle: both occur; outstanding unchanged.
- A freed tag is allocatable on the cycle after its response.
- Buffer write and response for the same tag in the same cycle: data output and response output both fire.

Counters and flags:
- outstanding = accepts − completions, range 0..NUM_TAGS.
- command_ready = (outstanding != NUM_TAGS), registered from the busy bitmap.

enabled=0:
- Inputs ha_* are still captured into the table, but outputs are held until enabled returns.
- Traffic while disabled is not supported; any such traffic is a testbench error.

Test Plan:
- Single read: command READ_CL_NA, address 0x1000, size 128, cmd.cu_id=1 → ah_cvalid next cycle, ah_ctag=0; bwad=0 then 1 → data_0 then data_1, each cmd.cu_id=1; ha_response=0x00 → read_response_out.valid one cycle later, outstanding back to 0.
- Saturation: 32 accepts with no responses → tags 0..31 issued in order, command_ready=0, outstanding=32; 33rd valid → protocol_error=1, no ah_cvalid.
- Out-of-order completion: tags 0,1,2 busy; respond 2,0,1 → responses carry matching stored cmd; next accept after tag 2 frees receives tag 0 only if tag 0 is free, otherwise the lowest free tag.
- Same-cycle accept + response on tag 5 → outstanding unchanged, tag 5 reusable the following cycle.
- Error code: ha_response=0x01 on tag 3 → read_response_out.response=0x01, tag 3 freed.
- Async reset asserted with 4 tags busy → all outputs 0 immediately; later ha_rvalid on tag 1 → protocol_error=1.

Source files
------------

// File: rtl/cu_read_response_engine.sv
// rtl/cu_read_response_engine.sv - PSL read command issue, tag tracking and response reassembly
package cu_rre_pkg;
  typedef struct packed {
    logic [7:0]  cu_id;
    logic [23:0] job_id;
  } CommandTagLine;

  typedef struct packed {
    logic          valid;
    logic [12:0]   command;
    logic [63:0]   address;
    logic [11:0]   size;
    CommandTagLine cmd;
  } CommandBufferLine;

  typedef struct packed {
    logic          valid;
    logic [511:0]  data;
    CommandTagLine cmd;
  } ReadWriteDataLine;

  typedef struct packed {
    logic          valid;
    logic [7:0]    response;
    CommandTagLine cmd;
  } ResponseBufferLine;
endpackage

module cu_read_response_engine
  import cu_rre_pkg::*;
#(
  parameter int NUM_TAGS  = 32,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 enabled,
  input  CommandBufferLine     command_in,
  output logic                 command_ready,
  output logic                 ah_cvalid,
  output logic [TAG_WIDTH-1:0] ah_ctag,
  output logic [12:0]          ah_com,
  output logic [63:0]          ah_cea,
  output logic [11:0]          ah_csize,
  input  logic                 ha_bwvalid,
  input  logic [TAG_WIDTH-1:0] ha_bwtag,
  input  logic [5:0]           ha_bwad,
  input  logic [511:0]         ha_bwdata,
  input  logic                 ha_rvalid,
  input  logic [TAG_WIDTH-1:0] ha_rtag,
  input  logic [7:0]           ha_response,
  output ReadWriteDataLine     read_data_0_out,
  output ReadWriteDataLine     read_data_1_out,
  output ResponseBufferLine    read_response_out,
  output logic [8:0]           outstanding,
  output logic                 protocol_error
);
  localparam int IDX_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [8:0]          cnt_q, cnt_d;
  logic                ready_q, ready_d, err_q, err_d;
  logic                cvalid_q, cvalid_d;
  logic [TAG_WIDTH-1:0] ctag_q, ctag_d;
  logic [12:0]         com_q, com_d;
  logic [63:0]         cea_q, cea_d;
  logic [11:0]         csize_q, csize_d;
  ReadWriteDataLine    rd0_q, rd0_d, rd1_q, rd1_d;
  ResponseBufferLine   rsp_q, rsp_d;
  CommandTagLine       cmd_tab_q [NUM_TAGS];

  logic             free_found, accept, cmd_err, bw_hit, rsp_hit, bw_in_range, rsp_in_range;
  logic [IDX_W-1:0] free_idx, bw_idx, rsp_idx;
  logic             unused_bwad;

  // Only bit 0 of the buffer address matters: it picks which 64B half is being returned.
  assign unused_bwad = ^ha_bwad[5:1];

  assign bw_idx       = ha_bwtag[IDX_W-1:0];
  assign rsp_idx      = ha_rtag[IDX_W-1:0];
  assign bw_in_range  = {1'b0, ha_bwtag} < (TAG_WIDTH+1)'(NUM_TAGS);
  assign rsp_in_range = {1'b0, ha_rtag} < (TAG_WIDTH+1)'(NUM_TAGS);

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end

    accept  = enabled && command_in.valid && ready_q && free_found;
    cmd_err = enabled && command_in.valid && !ready_q;
    bw_hit  = ha_bwvalid && bw_in_range && busy_q[bw_idx];
    rsp_hit = ha_rvalid && rsp_in_range && busy_q[rsp_idx];

    // Freeing precedes allocation, but allocation already used the old bitmap,
    // so a tag completing this cycle becomes allocatable on the next one.
    busy_d = busy_q;
    if (rsp_hit) busy_d[rsp_idx] = 1'b0;
    if (accept)  busy_d[free_idx] = 1'b1;

    cnt_d   = cnt_q + 9'(accept) - 9'(rsp_hit);
    ready_d = (cnt_d != 9'(NUM_TAGS));
    err_d   = err_q | cmd_err | (ha_bwvalid & ~bw_hit) | (ha_rvalid & ~rsp_hit);

    cvalid_d = cvalid_q;
    ctag_d   = ctag_q;
    com_d    = com_q;
    cea_d    = cea_q;
    csize_d  = csize_q;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    rsp_d    = rsp_q;
    if (enabled) begin
      cvalid_d = accept;
      ctag_d   = TAG_WIDTH'(free_idx);
      com_d    = command_in.command;
      cea_d    = command_in.address;
      csize_d  = command_in.size;
      rd0_d    = '{valid: bw_hit & ~ha_bwad[0], data: ha_bwdata, cmd: cmd_tab_q[bw_idx]};
      rd1_d    = '{valid: bw_hit &  ha_bwad[0], data: ha_bwdata, cmd: cmd_tab_q[bw_idx]};
      rsp_d    = '{valid: rsp_hit, response: ha_response, cmd: cmd_tab_q[rsp_idx]};
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      cvalid_q <= 1'b0;
      ctag_q   <= '0;
      com_q    <= '0;
      cea_q    <= '0;
      csize_q  <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
      rsp_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      cvalid_q <= cvalid_d;
      ctag_q   <= ctag_d;
      com_q    <= com_d;
      cea_q    <= cea_d;
      csize_q  <= csize_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
      rsp_q    <= rsp_d;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) cmd_tab_q[free_idx] <= command_in.cmd;
  end

  assign command_ready     = ready_q;
  assign ah_cvalid         = cvalid_q;
  assign ah_ctag           = ctag_q;
  assign ah_com            = com_q;
  assign ah_cea            = cea_q;
  assign ah_csize          = csize_q;
  assign read_data_0_out   = rd0_q;
  assign read_data_1_out   = rd1_q;
  assign read_response_out = rsp_q;
  assign outstanding       = cnt_q;
  assign protocol_error    = err_q;
endmodule

// File: tb/tb_cu_read_response_engine.sv
// tb/tb_cu_read_response_engine.sv - vector table plus scoreboard bench for cu_read_response_engine
module tb_cu_read_response_engine;
  import cu_rre_pkg::*;

  localparam logic [12:0] READ_CL_NA = 13'h0A00;

  logic clock = 1'b0;
  logic rst, enabled;
  CommandBufferLine command_in;
  logic command_ready, ah_cvalid;
  logic [7:0] ah_ctag;
  logic [12:0] ah_com;
  logic [63:0] ah_cea;
  logic [11:0] ah_csize;
  logic ha_bwvalid, ha_rvalid;
  logic [7:0] ha_bwtag, ha_rtag, ha_response;
  logic [5:0] ha_bwad;
  logic [511:0] ha_bwdata;
  ReadWriteDataLine read_data_0_out, read_data_1_out;
  ResponseBufferLine read_response_out;
  logic [8:0] outstanding;
  logic protocol_error;

  cu_read_response_engine #(.NUM_TAGS(32), .TAG_WIDTH(8)) dut (
    .clock(clock), .rst(rst), .enabled(enabled), .command_in(command_in),
    .command_ready(command_ready), .ah_cvalid(ah_cvalid), .ah_ctag(ah_ctag),
    .ah_com(ah_com), .ah_cea(ah_cea), .ah_csize(ah_csize),
    .ha_bwvalid(ha_bwvalid), .ha_bwtag(ha_bwtag), .ha_bwad(ha_bwad), .ha_bwdata(ha_bwdata),
    .ha_rvalid(ha_rvalid), .ha_rtag(ha_rtag), .ha_response(ha_response),
    .read_data_0_out(read_data_0_out), .read_data_1_out(read_data_1_out),
    .read_response_out(read_response_out), .outstanding(outstanding),
    .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] tag; logic [12:0] com; logic [63:0] cea; logic [11:0] csize; } iss_t;
  typedef struct { logic half; logic [511:0] data; CommandTagLine cmd; } dat_t;
  typedef struct { logic [7:0] code; CommandTagLine cmd; } rsp_t;
  typedef struct {
    bit cv; logic [7:0] cu; logic [7:0] etag;
    bit bv; logic [7:0] bt; bit bh;
    bit rv; logic [7:0] rt; logic [7:0] code;
    int eout;
  } vec_t;

  iss_t iss_q[$];
  dat_t dat_q[$];
  rsp_t rsp_q[$];
  vec_t tbl[$];
  CommandTagLine mdl_cmd [256];
  int n_vec = 0;
  int n_bad = 0;
  int seq = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_data(input int half, input ReadWriteDataLine o);
    dat_t e;
    if (dat_q.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL unexpected_data%0d: valid with empty scoreboard", half);
    end else begin
      e = dat_q.pop_front();
      chk("data_half", 512'(half), 512'(e.half));
      chk("data_payload", o.data, e.data);
      chk("data_cmd", 512'(o.cmd), 512'(e.cmd));
    end
  endtask

  always @(negedge clock) begin
    iss_t ei;
    rsp_t er;
    if (!rst) begin
      if (ah_cvalid) begin
        if (iss_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_issue: tag %0h with empty scoreboard", ah_ctag);
        end else begin
          ei = iss_q.pop_front();
          chk("ah_ctag", 512'(ah_ctag), 512'(ei.tag));
          chk("ah_com", 512'(ah_com), 512'(ei.com));
          chk("ah_cea", 512'(ah_cea), 512'(ei.cea));
          chk("ah_csize", 512'(ah_csize), 512'(ei.csize));
        end
      end
      if (read_data_0_out.valid && read_data_1_out.valid) begin
        n_vec++; n_bad++;
        $display("FAIL both_halves_valid: got 1 1 expected one");
      end
      if (read_data_0_out.valid) check_data(0, read_data_0_out);
      if (read_data_1_out.valid) check_data(1, read_data_1_out);
      if (read_response_out.valid) begin
        if (rsp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_response: code %0h with empty scoreboard", read_response_out.response);
        end else begin
          er = rsp_q.pop_front();
          chk("rsp_code", 512'(read_response_out.response), 512'(er.code));
          chk("rsp_cmd", 512'(read_response_out.cmd), 512'(er.cmd));
        end
      end
    end
  end

  task automatic clear_inputs();
    command_in = '0;
    ha_bwvalid = 1'b0; ha_bwtag = '0; ha_bwad = '0; ha_bwdata = '0;
    ha_rvalid = 1'b0; ha_rtag = '0; ha_response = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cycle(input vec_t v);
    CommandTagLine c;
    logic [511:0] d;
    logic [63:0] a;
    clear_inputs();
    if (v.cv) begin
      seq++;
      c.cu_id = v.cu;
      c.job_id = 24'(seq);
      a = 64'h1000 + 64'(seq - 1) * 64'h80;
      command_in.valid = 1'b1; command_in.command = READ_CL_NA;
      command_in.address = a; command_in.size = 12'd128; command_in.cmd = c;
      iss_q.push_back('{v.etag, READ_CL_NA, a, 12'd128});
      mdl_cmd[v.etag] = c;
    end
    if (v.bv) begin
      for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
      ha_bwvalid = 1'b1; ha_bwtag = v.bt; ha_bwad = {5'd0, v.bh}; ha_bwdata = d;
      dat_q.push_back('{v.bh, d, mdl_cmd[v.bt]});
    end
    if (v.rv) begin
      ha_rvalid = 1'b1; ha_rtag = v.rt; ha_response = v.code;
      rsp_q.push_back('{v.code, mdl_cmd[v.rt]});
    end
    step();
    clear_inputs();
  endtask

  function automatic vec_t mk(bit cv, int cu, int etag, bit bv, int bt, bit bh,
                              bit rv, int rt, int code, int eout);
    vec_t v;
    v.cv = cv; v.cu = 8'(cu); v.etag = 8'(etag);
    v.bv = bv; v.bt = 8'(bt); v.bh = bh;
    v.rv = rv; v.rt = 8'(rt); v.code = 8'(code); v.eout = eout;
    return v;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cvalid"}, 512'(ah_cvalid), 512'(0));
    chk({tag, "_ctag"}, 512'(ah_ctag), 512'(0));
    chk({tag, "_cea"}, 512'(ah_cea), 512'(0));
    chk({tag, "_ready"}, 512'(command_ready), 512'(0));
    chk({tag, "_outstanding"}, 512'(outstanding), 512'(0));
    chk({tag, "_perr"}, 512'(protocol_error), 512'(0));
    chk({tag, "_rd0_valid"}, 512'(read_data_0_out.valid), 512'(0));
    chk({tag, "_rd1_data"}, read_data_1_out.data, 512'(0));
    chk({tag, "_rsp"}, 512'(read_response_out), 512'(0));
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_zero(tag);
    iss_q.delete(); dat_q.delete(); rsp_q.delete();
    step();
    rst = 1'b0;
    idle(2);
  endtask

  initial begin
    rst = 1'b1; enabled = 1'b1;
    clear_inputs();
    #12 check_zero("reset");
    step();
    rst = 1'b0;
    idle(2);
    chk("ready_after_reset", 512'(command_ready), 512'(1));

    // single read, out-of-order completion, error code, same-cycle events
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 4, 2, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 8'h00, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 1));
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 8'h00, 1));
    tbl.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 7, 2, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 8, 3, 0, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 8'h01, 3));
    tbl.push_back(mk(0, 0, 0, 1, 2, 1, 1, 2, 8'h00, 2));
    tbl.push_back(mk(1, 9, 2, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 10, 3, 0, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, 11, 4, 0, 0, 0, 0, 0, 0, 5));
    tbl.push_back(mk(1, 12, 5, 1, 1, 0, 0, 0, 0, 6));
    tbl.push_back(mk(1, 13, 6, 0, 0, 0, 1, 5, 8'h00, 6));
    tbl.push_back(mk(1, 14, 5, 0, 0, 0, 0, 0, 0, 7));
    for (int t = 0; t < 7; t++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, t, 8'h00, 6 - t));

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i]);
      chk($sformatf("outstanding_v%0d", i), 512'(outstanding), 512'(tbl[i].eout));
    end
    idle(2);
    chk("perr_after_table", 512'(protocol_error), 512'(0));

    // saturation
    for (int i = 0; i < 32; i++) begin
      cycle(mk(1, 16 + i, i, 0, 0, 0, 0, 0, 0, 0));
      chk($sformatf("sat_outstanding_%0d", i), 512'(outstanding), 512'(i + 1));
    end
    chk("sat_ready", 512'(command_ready), 512'(0));
    clear_inputs();
    command_in.valid = 1'b1; command_in.command = READ_CL_NA; command_in.size = 12'd128;
    step();
    clear_inputs();
    idle(2);
    chk("sat_perr", 512'(protocol_error), 512'(1));
    chk("sat_outstanding_hold", 512'(outstanding), 512'(32));

    async_reset("reset_full");
    for (int i = 0; i < 4; i++) cycle(mk(1, 60 + i, i, 0, 0, 0, 0, 0, 0, 0));
    idle(1);
    chk("four_busy", 512'(outstanding), 512'(4));
    async_reset("reset_four");
    ha_rvalid = 1'b1; ha_rtag = 8'd1; ha_response = 8'h00;
    step();
    clear_inputs();
    idle(2);
    chk("stale_rsp_perr", 512'(protocol_error), 512'(1));
    chk("stale_rsp_outstanding", 512'(outstanding), 512'(0));

    // disabled: command ignored, no issue, no count change
    enabled = 1'b0;
    command_in.valid = 1'b1; command_in.command = READ_CL_NA; command_in.size = 12'd128;
    step();
    clear_inputs();
    enabled = 1'b1;
    idle(2);
    chk("disabled_outstanding", 512'(outstanding), 512'(0));

    chk("iss_q_empty", 512'(iss_q.size()), 512'(0));
    chk("dat_q_empty", 512'(dat_q.size()), 512'(0));
    chk("rsp_q_empty", 512'(rsp_q.size()), 512'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
